// File: rtl/mips32_loader_pkg.sv
// Shared definitions for the MIPS32 program loader: FSM state encoding,
// stream byte / instruction word widths and the running checksum step.
package mips32_loader_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA,
    CSUM,
    DONE,
    ERROR
  } state_t;

  // One step of the running XOR checksum over data bytes.
  function automatic logic [BYTE_W-1:0] csum_next(input logic [BYTE_W-1:0] acc,
                                                  input logic [BYTE_W-1:0] data);
    return acc ^ data;
  endfunction

endpackage

// File: rtl/mips32_word_asm.sv
// Word assembler: shifts stream bytes MSB-first into a 32-bit register and
// flags the byte that completes a word. word_next is the word including the
// byte currently being shifted, so the caller can register it directly.
module mips32_word_asm
  import mips32_loader_pkg::*;
(
  input  logic              clk1,
  input  logic              rst,
  input  logic              shift_en,
  input  logic [BYTE_W-1:0] byte_in,
  output logic              word_last,
  output logic [WORD_W-1:0] word_next
);

  logic [1:0]        byte_cnt;
  logic [WORD_W-1:0] shreg;

  assign word_next = {shreg[WORD_W-BYTE_W-1:0], byte_in};
  assign word_last = shift_en && (byte_cnt == 2'd3);

  // Byte counter and shift register; reset discards any partial word.
  always_ff @(posedge clk1) begin
    if (rst) begin
      byte_cnt <= '0;
      shreg    <= '0;
    end else if (shift_en) begin
      byte_cnt <= byte_cnt + 2'd1;
      shreg    <= word_next;
    end
  end

endmodule

// File: rtl/mips32_prog_loader.sv
// MIPS32 program loader: receives a length-prefixed byte stream, writes
// assembled instruction words into instruction memory and holds the CPU
// halted until the load completes.
// Optional macro LOADER_CSUM_EN: compare the trailing checksum byte against
// the XOR of all data bytes (without it the byte is consumed unchecked).
module mips32_prog_loader
  import mips32_loader_pkg::*;
#(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              cpu_halt,
  output logic              done,
  output logic              error,
  output logic [15:0]       words_loaded
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  state_t            state;
  logic [15:0]       len_q;
  logic [15:0]       word_cnt;
  logic [ADDR_W-1:0] word_idx;
  logic              xfer;
  logic              word_last;
  logic [WORD_W-1:0] word_next;
`ifdef LOADER_CSUM_EN
  logic [BYTE_W-1:0] csum;
`endif

  assign xfer = in_valid && in_ready;

  mips32_word_asm u_word_asm (
    .clk1      (clk1),
    .rst       (rst),
    .shift_en  (xfer && (state == DATA)),
    .byte_in   (in_data),
    .word_last (word_last),
    .word_next (word_next)
  );

  // Loader FSM with registered handshake, memory-write and status outputs.
  // The last word moves straight to CSUM; in_ready stays low through its
  // mem_we cycle, so no checksum byte can be taken before the write.
  always_ff @(posedge clk1) begin
    if (rst) begin
      state        <= IDLE;
      in_ready     <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= BASE;
      mem_wdata    <= '0;
      cpu_halt     <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
      len_q        <= '0;
      word_cnt     <= '0;
      word_idx     <= '0;
`ifdef LOADER_CSUM_EN
      csum         <= '0;
`endif
    end else begin
      mem_we <= 1'b0;
      case (state)
        IDLE: begin
          state    <= LEN_HI;
          in_ready <= 1'b1;
        end
        LEN_HI: begin
          if (xfer) begin
            len_q[15:8] <= in_data;
            state       <= LEN_LO;
          end
        end
        LEN_LO: begin
          if (xfer) begin
            len_q[7:0] <= in_data;
            state      <= ({len_q[15:8], in_data} == 16'd0) ? CSUM : DATA;
          end
        end
        DATA: begin
          in_ready <= 1'b1;
          if (xfer) begin
`ifdef LOADER_CSUM_EN
            csum <= csum_next(csum, in_data);
`endif
            if (word_last) begin
              mem_we    <= 1'b1;
              mem_wdata <= word_next;
              mem_addr  <= BASE + word_idx;
              word_idx  <= word_idx + ADDR_W'(1);
              word_cnt  <= word_cnt + 16'd1;
              in_ready  <= 1'b0;
              if (words_loaded != 16'hFFFF) begin
                words_loaded <= words_loaded + 16'd1;
              end
              if (word_cnt + 16'd1 == len_q) begin
                state <= CSUM;
              end
            end
          end
        end
        CSUM: begin
          in_ready <= 1'b1;
          if (xfer) begin
            in_ready <= 1'b0;
`ifdef LOADER_CSUM_EN
            if (in_data == csum) begin
              state    <= DONE;
              done     <= 1'b1;
              cpu_halt <= 1'b0;
            end else begin
              state <= ERROR;
              error <= 1'b1;
            end
`else
            state    <= DONE;
            done     <= 1'b1;
            cpu_halt <= 1'b0;
`endif
          end
        end
        DONE, ERROR: begin
          in_ready <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips32_prog_loader.sv
// Scoreboard bench for mips32_prog_loader: stimulus pushes expected memory
// writes into per-DUT queues, monitors pop and compare on every mem_we.
module tb_mips32_prog_loader;

  logic clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  logic        rst_a = 1'b1;
  logic        rst_b = 1'b1;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;

  logic        in_ready_a, mem_we_a, cpu_halt_a, done_a, error_a;
  logic [9:0]  mem_addr_a;
  logic [31:0] mem_wdata_a;
  logic [15:0] words_loaded_a;

  logic        in_ready_b, mem_we_b, cpu_halt_b, done_b, error_b;
  logic [1:0]  mem_addr_b;
  logic [31:0] mem_wdata_b;
  logic [15:0] words_loaded_b;

  mips32_prog_loader #(.ADDR_W(10), .BASE_ADDR(0)) dut (
    .clk1(clk1), .rst(rst_a), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_a), .mem_we(mem_we_a), .mem_addr(mem_addr_a),
    .mem_wdata(mem_wdata_a), .cpu_halt(cpu_halt_a), .done(done_a),
    .error(error_a), .words_loaded(words_loaded_a)
  );

  mips32_prog_loader #(.ADDR_W(2), .BASE_ADDR(0)) dut_w2 (
    .clk1(clk1), .rst(rst_b), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b),
    .mem_wdata(mem_wdata_b), .cpu_halt(cpu_halt_b), .done(done_b),
    .error(error_b), .words_loaded(words_loaded_b)
  );

  typedef struct packed {
    logic [9:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t         q_a[$];
  wr_t         q_b[$];
  logic [31:0] wl[$];
  int          checks = 0;
  int          errors = 0;
  bit          sel_b  = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  // Monitor for the ADDR_W=10 instance.
  always @(negedge clk1) begin
    wr_t e;
    if (!rst_a && mem_we_a) begin
      checks++;
      if (q_a.size() == 0) begin
        errors++;
        $display("FAIL wr_a unexpected write addr %h data %h", mem_addr_a, mem_wdata_a);
      end else begin
        e = q_a.pop_front();
        if (mem_addr_a !== e.addr || mem_wdata_a !== e.data || in_ready_a !== 1'b0) begin
          errors++;
          $display("FAIL wr_a got addr %h data %h ready %b expected addr %h data %h ready 0",
                   mem_addr_a, mem_wdata_a, in_ready_a, e.addr, e.data);
        end
      end
    end
  end

  // Monitor for the ADDR_W=2 instance.
  always @(negedge clk1) begin
    wr_t e;
    if (!rst_b && mem_we_b) begin
      checks++;
      if (q_b.size() == 0) begin
        errors++;
        $display("FAIL wr_b unexpected write addr %h data %h", mem_addr_b, mem_wdata_b);
      end else begin
        e = q_b.pop_front();
        if ({8'b0, mem_addr_b} !== e.addr || mem_wdata_b !== e.data || in_ready_b !== 1'b0) begin
          errors++;
          $display("FAIL wr_b got addr %h data %h ready %b expected addr %h data %h ready 0",
                   mem_addr_b, mem_wdata_b, in_ready_b, e.addr, e.data);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int unsigned n = 0;
    bit sent = 1'b0;
    while (!sent) begin
      @(negedge clk1);
      in_data  = b;
      in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      if (in_valid && (sel_b ? in_ready_b : in_ready_a)) sent = 1'b1;
      n++;
      if (!sent && n > 200) begin
        checks++;
        errors++;
        $display("FAIL byte_timeout byte %h never accepted", b);
        return;
      end
    end
  endtask

  task automatic push_exp(input int unsigned idx, input logic [31:0] w);
    wr_t e;
    e.data = w;
    if (sel_b) begin
      e.addr = 10'(idx % 4);
      q_b.push_back(e);
    end else begin
      e.addr = 10'(idx);
      q_a.push_back(e);
    end
  endtask

  task automatic send_stream(input bit bad_csum, input bit gaps);
    logic [7:0]  cs = '0;
    logic [15:0] nn;
    logic [31:0] w;
    nn = 16'(wl.size());
    for (int unsigned i = 0; i < wl.size(); i++) begin
      w = wl[i];
      push_exp(i, w);
      cs = cs ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
    end
    send_byte(nn[15:8], gaps);
    send_byte(nn[7:0], gaps);
    for (int unsigned i = 0; i < wl.size(); i++) begin
      w = wl[i];
      send_byte(w[31:24], gaps);
      send_byte(w[23:16], gaps);
      send_byte(w[15:8], gaps);
      send_byte(w[7:0], gaps);
    end
    send_byte(bad_csum ? (cs ^ 8'h01) : cs, gaps);
    @(negedge clk1);
    in_valid = 1'b0;
  endtask

  task automatic wait_end(input string name);
    int unsigned n = 0;
    while (!(sel_b ? (done_b || error_b) : (done_a || error_a))) begin
      @(negedge clk1);
      n++;
      if (n > 500) begin
        checks++;
        errors++;
        $display("FAIL %s timeout waiting for done or error", name);
        return;
      end
    end
    repeat (2) @(negedge clk1);
  endtask

  task automatic reset_a();
    rst_a    = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk1);
    @(negedge clk1);
    chk("rst_in_ready", in_ready_a, 0);
    chk("rst_mem_we", mem_we_a, 0);
    chk("rst_mem_addr", mem_addr_a, 0);
    chk("rst_mem_wdata", mem_wdata_a, 0);
    chk("rst_cpu_halt", cpu_halt_a, 1);
    chk("rst_done", done_a, 0);
    chk("rst_error", error_a, 0);
    chk("rst_words", words_loaded_a, 0);
    rst_a = 1'b0;
  endtask

  task automatic end_checks_a(input string name, input bit exp_done, input logic [15:0] exp_words);
    chk({name, "_done"}, done_a, exp_done);
    chk({name, "_error"}, error_a, !exp_done);
    chk({name, "_cpu_halt"}, cpu_halt_a, !exp_done);
    chk({name, "_in_ready"}, in_ready_a, 0);
    chk({name, "_words"}, words_loaded_a, exp_words);
    chk({name, "_pending"}, q_a.size(), 0);
    q_a.delete();
  endtask

  initial begin
    // Three-word program, checksum 00^43^28^00 ^ 04^43^38^00 ^ 14^43^48^00 = 0B.
    reset_a();
    wl = '{32'h00432800, 32'h04433800, 32'h14434800};
    send_stream(1'b0, 1'b0);
    wait_end("basic");
    end_checks_a("basic", 1'b1, 16'd3);

    // Same program with in_valid gapped at random.
    reset_a();
    send_stream(1'b0, 1'b1);
    wait_end("gaps");
    end_checks_a("gaps", 1'b1, 16'd3);

    // One word, checksum deliberately wrong (correct would be 60).
    reset_a();
    wl = '{32'h284B0003};
    send_stream(1'b1, 1'b0);
    wait_end("badcs");
`ifdef LOADER_CSUM_EN
    end_checks_a("badcs", 1'b0, 16'd1);
`else
    end_checks_a("badcs", 1'b1, 16'd1);
`endif

    // Zero-length load, then bytes offered in DONE must be ignored.
    reset_a();
    wl.delete();
    send_stream(1'b0, 1'b0);
    wait_end("empty");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk1);
      in_data  = 8'hAA;
      in_valid = 1'b1;
    end
    @(negedge clk1);
    in_valid = 1'b0;
    repeat (2) @(negedge clk1);
    end_checks_a("empty", 1'b1, 16'd0);

    // Reset after 6 data bytes of a 2-word load: the first word is written,
    // the half-built second word is discarded, then a fresh 1-word load.
    reset_a();
    push_exp(0, 32'h11223344);
    send_byte(8'h00, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b0);
    send_byte(8'h55, 1'b0);
    send_byte(8'h66, 1'b0);
    @(negedge clk1);
    in_valid = 1'b0;
    chk("abort_pending", q_a.size(), 0);
    reset_a();
    wl = '{32'hDEADBEEF};
    send_stream(1'b0, 1'b0);
    wait_end("abort");
    end_checks_a("abort", 1'b1, 16'd1);

    // ADDR_W=2 instance: five words, word index wraps to 0.
    rst_a = 1'b1;
    sel_b = 1'b1;
    repeat (2) @(negedge clk1);
    rst_b = 1'b0;
    wl = '{32'h01020304, 32'hA0B0C0D0, 32'h12345678, 32'hCAFEF00D, 32'h0000FFFF};
    send_stream(1'b0, 1'b1);
    wait_end("wrap");
    chk("wrap_done", done_b, 1);
    chk("wrap_error", error_b, 0);
    chk("wrap_cpu_halt", cpu_halt_b, 0);
    chk("wrap_words", words_loaded_b, 16'd5);
    chk("wrap_pending", q_b.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
